cop_mem_seq: RTL and testbench

COP_MEM_SEQ -- requirements
Module: cop_mem_seq

---
 rtl/cop_mem_seq_pkg.sv | 15 +
 rtl/cop_mem_seq.sv | 152 +++++++++++++++
 tb/tb_cop_mem_seq.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cop_mem_seq_pkg.sv
// Shared definitions for the coprocessor memory sequencer: state encodings
// and the number of transaction slots an instruction can carry.
package cop_mem_seq_pkg;

  localparam int TXN_SLOTS = 4;
  localparam int IDX_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/cop_mem_seq.sv
// Splits one instruction-level request into up to four sequential memory
// transactions, one outstanding at a time, and gathers the results.
module cop_mem_seq
  import cop_mem_seq_pkg::*;
#(
  parameter int MAX_TXN = TXN_SLOTS
) (
  input  logic         vtx_clk,
  input  logic         vtx_reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_count,
  input  logic         req_wen,
  input  logic [127:0] req_addr,
  input  logic [127:0] req_wdata,
  input  logic [15:0]  req_ben,
  output logic         mem_cen,
  output logic         mem_wen,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_ben,
  input  logic         mem_stall,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_error,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_rdata,
  output logic         rsp_error,
  output logic [1:0]   rsp_err_idx,
  output logic [3:0]   log_cen,
  output logic [3:0]   log_error
);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg;
  logic [2:0]         count_reg;
  logic               wen_reg;
  logic [127:0]       addr_reg, wdata_reg, rdata_reg;
  logic [15:0]        ben_reg;
  logic               error_reg;
  logic [IDX_W-1:0]   err_idx_reg;
  logic [3:0]         log_cen_reg, log_error_reg;

  logic [31:0]        addr_slot  [TXN_SLOTS];
  logic [31:0]        wdata_slot [TXN_SLOTS];
  logic [3:0]         ben_slot   [TXN_SLOTS];

  logic count_bad;
  logic count_zero;
  logic last_txn;

  assign count_bad  = (req_count > 3'(MAX_TXN));
  assign count_zero = (req_count == 3'd0);
  assign last_txn   = ({1'b0, idx_reg} == (count_reg - 3'd1));

  for (genvar gi = 0; gi < TXN_SLOTS; gi++) begin : g_slot
    assign addr_slot[gi]  = addr_reg[32*gi +: 32];
    assign wdata_slot[gi] = wdata_reg[32*gi +: 32];
    assign ben_slot[gi]   = ben_reg[4*gi +: 4];
  end

  always_ff @(posedge vtx_clk or posedge vtx_reset) begin
    if (vtx_reset) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req_valid) state_next = (count_zero || count_bad) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (!mem_stall) state_next = ST_WAIT;
      ST_WAIT:  if (mem_rvalid) state_next = (mem_error || last_txn) ? ST_RESP : ST_ISSUE;
      ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Slot fields are only presented while a request is on the bus.
  always_comb begin
    req_ready = 1'b0;
    mem_cen   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_ben   = '0;
    rsp_valid = 1'b0;
    case (state_reg)
      ST_IDLE:  req_ready = 1'b1;
      ST_ISSUE: begin
        mem_cen   = 1'b1;
        mem_wen   = wen_reg;
        mem_addr  = addr_slot[idx_reg];
        mem_wdata = wdata_slot[idx_reg];
        mem_ben   = ben_slot[idx_reg];
      end
      ST_RESP:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge vtx_clk or posedge vtx_reset) begin
    if (vtx_reset) begin
      idx_reg       <= '0;
      count_reg     <= '0;
      wen_reg       <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      ben_reg       <= '0;
      rdata_reg     <= '0;
      error_reg     <= 1'b0;
      err_idx_reg   <= '0;
      log_cen_reg   <= '0;
      log_error_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (req_valid) begin
          idx_reg       <= '0;
          count_reg     <= req_count;
          wen_reg       <= req_wen;
          addr_reg      <= req_addr;
          wdata_reg     <= req_wdata;
          ben_reg       <= req_ben;
          rdata_reg     <= '0;
          error_reg     <= count_bad;
          err_idx_reg   <= '0;
          log_cen_reg   <= '0;
          log_error_reg <= '0;
        end
        ST_ISSUE: if (!mem_stall) log_cen_reg[idx_reg] <= 1'b1;
        ST_WAIT: if (mem_rvalid) begin
          if (!wen_reg) rdata_reg[{idx_reg, 5'd0} +: 32] <= mem_rdata;
          if (mem_error) begin
            log_error_reg[idx_reg] <= 1'b1;
            error_reg              <= 1'b1;
            err_idx_reg            <= idx_reg;
          end else if (!last_txn) begin
            idx_reg <= idx_reg + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata   = rdata_reg;
  assign rsp_error   = error_reg;
  assign rsp_err_idx = err_idx_reg;
  assign log_cen     = log_cen_reg;
  assign log_error   = log_error_reg;

endmodule

// File: tb/tb_cop_mem_seq.sv
// Self-checking bench for cop_mem_seq: table of instruction scenarios driven
// against a small memory responder, with a scoreboard of expected responses.
module tb_cop_mem_seq;

  logic         vtx_clk = 1'b0;
  logic         vtx_reset;
  logic         req_valid, req_ready, req_wen;
  logic [2:0]   req_count;
  logic [127:0] req_addr, req_wdata;
  logic [15:0]  req_ben;
  logic         mem_cen, mem_wen, mem_stall, mem_rvalid, mem_error;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_ben;
  logic         rsp_valid, rsp_ready, rsp_error;
  logic [127:0] rsp_rdata;
  logic [1:0]   rsp_err_idx;
  logic [3:0]   log_cen, log_error;

  cop_mem_seq #(.MAX_TXN(4)) dut (
    .vtx_clk(vtx_clk), .vtx_reset(vtx_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_count(req_count),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_ben(req_ben),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ben(mem_ben), .mem_stall(mem_stall), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_error(mem_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_err_idx(rsp_err_idx),
    .log_cen(log_cen), .log_error(log_error)
  );

  always #5 vtx_clk = ~vtx_clk;

  typedef struct {
    int          count;
    bit          wen;
    int          stall0;
    int          err_txn;
    int          hold;
    bit          exp_err;
    int          exp_err_idx;
    logic [3:0]  exp_lc;
    logic [3:0]  exp_le;
    int          exp_cycle;
    logic [31:0] addr_base;
    logic [31:0] data_base;
  } vec_t;

  typedef struct {
    logic [127:0] rdata;
    bit           err;
    logic [1:0]   err_idx;
    logic [3:0]   lc;
    logic [3:0]   le;
    int           cycle;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[8];

  int n_tests = 0;
  int n_fail  = 0;

  // Responder / current-instruction state
  logic [31:0] g_addr_base, g_data_base;
  int          g_vi, g_err_txn, stall_left, cur_txn, pend_txn, n_cen;
  bit          g_wen, pend;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slot_addr(input int i);
    return g_addr_base + 32'(4 * i);
  endfunction
  function automatic logic [31:0] slot_wdata(input int i);
    return 32'hC0DE_0000 + 32'(g_vi * 16 + i);
  endfunction
  function automatic logic [3:0] slot_ben(input int i);
    return 4'(i * 5 + g_vi + 1);
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_outs_zero"},
          {mem_cen, mem_wen, mem_addr, mem_wdata, mem_ben, rsp_valid,
           rsp_error, rsp_err_idx, log_cen, log_error}, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
  endtask

  // One negedge step of the memory model: answer last cycle's accepted
  // request, then look at the request on the bus now.
  task automatic mem_step();
    mem_rvalid = 1'b0;
    mem_error  = 1'b0;
    mem_rdata  = '0;
    mem_stall  = 1'b0;
    if (pend) begin
      mem_rvalid = 1'b1;
      mem_error  = (pend_txn == g_err_txn);
      mem_rdata  = mem_error ? 32'h0 : g_data_base + 32'(pend_txn);
      pend = 1'b0;
    end
    if (mem_cen) begin
      n_cen++;
      if (cur_txn > 3) begin
        check($sformatf("v%0d_extra_cen", g_vi), mem_cen, 0);
      end else begin
        check($sformatf("v%0d_t%0d_bus", g_vi, cur_txn),
              {mem_wen, mem_addr, mem_wdata, mem_ben},
              {g_wen, slot_addr(cur_txn), slot_wdata(cur_txn), slot_ben(cur_txn)});
        if (cur_txn == 0 && stall_left > 0) begin
          mem_stall = 1'b1;
          stall_left--;
        end else begin
          pend     = 1'b1;
          pend_txn = cur_txn;
          cur_txn++;
        end
      end
    end
  endtask

  task automatic drive_req(input vec_t v, input int vi);
    g_vi        = vi;
    g_addr_base = v.addr_base;
    g_data_base = v.data_base;
    g_wen       = v.wen;
    g_err_txn   = v.err_txn;
    stall_left  = v.stall0;
    cur_txn     = 0;
    pend        = 1'b0;
    n_cen       = 0;
    req_valid   = 1'b1;
    req_count   = 3'(v.count);
    req_wen     = v.wen;
    for (int i = 0; i < 4; i++) begin
      req_addr[32*i +: 32]  = slot_addr(i);
      req_wdata[32*i +: 32] = slot_wdata(i);
      req_ben[4*i +: 4]     = slot_ben(i);
    end
    check($sformatf("v%0d_req_ready", vi), req_ready, 1);
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    exp_t e, got;
    int   cycle;
    bit   found, ok_cnt, exec;

    ok_cnt  = (v.count >= 1 && v.count <= 4);
    e.rdata = '0;
    for (int i = 0; i < 4; i++) begin
      exec = ok_cnt && (i < v.count) && (v.err_txn < 0 || i <= v.err_txn);
      if (exec && !v.wen && i != v.err_txn) e.rdata[32*i +: 32] = v.data_base + 32'(i);
    end
    e.err     = v.exp_err;
    e.err_idx = 2'(v.exp_err_idx);
    e.lc      = v.exp_lc;
    e.le      = v.exp_le;
    e.cycle   = v.exp_cycle;
    sb.push_back(e);

    drive_req(v, vi);
    @(negedge vtx_clk);
    req_valid = 1'b0;
    cycle = 1;
    found = 1'b0;
    while (!found && cycle <= 100) begin
      if (rsp_valid) begin
        found = 1'b1;
      end else begin
        mem_step();
        @(negedge vtx_clk);
        cycle++;
      end
    end
    mem_rvalid = 1'b0;
    mem_error  = 1'b0;
    mem_stall  = 1'b0;
    got = sb.pop_front();
    if (!found) begin
      check($sformatf("v%0d_rsp_timeout", vi), 0, 1);
      return;
    end
    check($sformatf("v%0d_rsp_cycle", vi), cycle, got.cycle);
    check($sformatf("v%0d_rsp_rdata", vi), rsp_rdata, got.rdata);
    check($sformatf("v%0d_rsp_err", vi), {rsp_error, rsp_err_idx}, {got.err, got.err_idx});
    check($sformatf("v%0d_logs", vi), {log_cen, log_error}, {got.lc, got.le});
    check($sformatf("v%0d_n_issued", vi), n_cen - v.stall0, $countones(v.exp_lc));
    $display("[TB] vec %0d count=%0d wen=%0d stall=%0d err_txn=%0d -> cycle=%0d err=%0d idx=%0d lc=%b le=%b",
             vi, v.count, v.wen, v.stall0, v.err_txn, cycle, rsp_error, rsp_err_idx, log_cen, log_error);

    for (int h = 0; h < v.hold; h++) begin
      @(negedge vtx_clk);
      check($sformatf("v%0d_hold%0d_ctl", vi, h), {rsp_valid, req_ready, mem_cen}, 3'b100);
      check($sformatf("v%0d_hold%0d_rsp", vi, h),
            {rsp_rdata, rsp_error, rsp_err_idx, log_cen, log_error},
            {got.rdata, got.err, got.err_idx, got.lc, got.le});
    end
    rsp_ready = 1'b1;
    @(negedge vtx_clk);
    rsp_ready = 1'b0;
    check($sformatf("v%0d_back_idle", vi), {req_ready, rsp_valid}, 2'b10);
  endtask

  initial begin
    tbl[0] = '{4, 1'b0, 0, -1, 0, 1'b0, 0, 4'b1111, 4'b0000, 9, 32'h100, 32'hA0};
    tbl[1] = '{2, 1'b1, 3, -1, 0, 1'b0, 0, 4'b0011, 4'b0000, 8, 32'h200, 32'hB0};
    tbl[2] = '{3, 1'b0, 0,  1, 0, 1'b1, 1, 4'b0011, 4'b0010, 5, 32'h300, 32'hC0};
    tbl[3] = '{0, 1'b0, 0, -1, 0, 1'b0, 0, 4'b0000, 4'b0000, 1, 32'h400, 32'hD0};
    tbl[4] = '{6, 1'b0, 0, -1, 0, 1'b1, 0, 4'b0000, 4'b0000, 1, 32'h500, 32'hE0};
    tbl[5] = '{1, 1'b0, 0, -1, 5, 1'b0, 0, 4'b0001, 4'b0000, 3, 32'h600, 32'hF0};
    tbl[6] = '{2, 1'b0, 0,  0, 0, 1'b1, 0, 4'b0001, 4'b0001, 3, 32'h700, 32'h1234_0000};
    tbl[7] = '{4, 1'b1, 0,  3, 2, 1'b1, 3, 4'b1111, 4'b1000, 9, 32'h800, 32'h5678_0000};

    vtx_reset  = 1'b1;
    req_valid  = 1'b0;
    req_count  = '0;
    req_wen    = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_ben    = '0;
    mem_stall  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_error  = 1'b0;
    rsp_ready  = 1'b0;
    pend       = 1'b0;
    #1;
    check_idle_zero("por");
    @(negedge vtx_clk);
    vtx_reset = 1'b0;
    @(negedge vtx_clk);

    for (int vi = 0; vi < 8; vi++) run_vec(tbl[vi], vi);

    // Reset while waiting on txn 2, then a stray response afterwards.
    drive_req(tbl[0], 20);
    @(negedge vtx_clk);
    req_valid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (pend && cur_txn == 3) break;
      mem_step();
      @(negedge vtx_clk);
    end
    check("mid_rst_in_wait", {pend, mem_cen, rsp_valid}, 3'b100);
    mem_rvalid = 1'b0;
    vtx_reset  = 1'b1;
    #1;
    check_idle_zero("mid_rst");
    @(negedge vtx_clk);
    vtx_reset  = 1'b0;
    pend       = 1'b0;
    mem_rvalid = 1'b1;
    mem_error  = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    @(negedge vtx_clk);
    mem_rvalid = 1'b0;
    mem_error  = 1'b0;
    mem_rdata  = '0;
    check_idle_zero("stray_rvalid");
    $display("[TB] reset during txn 2 wait: req_ready=%0d rsp_valid=%0d log_cen=%b",
             req_ready, rsp_valid, log_cen);

    run_vec(tbl[0], 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck, want finish");
    $fatal(1, "timeout");
  end

endmodule
